// File: rtl/echo_tof_detector.sv
// ============================================================================
// echo_tof_detector
//
// Ultrasonic echo time-of-flight detector. A start pulse (transmit burst
// emitted) launches a free-running timer. Echo edges are ignored during the
// ringdown blanking window. After that, an echo is accepted once MIN_EDGES
// consecutive rising edges arrive with edge-to-edge gaps within
// PULSE_PERIOD_CYCLES +/- PERIOD_TOL_CYCLES. The timestamp of the first edge
// of the accepted train is reported as the time of flight. If nothing
// qualifies before MAX_TOF_CYCLES the measurement times out.
//
// valid_out and timeout_out are registered. Each is a one-cycle pulse in the
// cycle after the deciding timer value, which is also the first cycle with
// busy_out low.
//
// Optional build macro: ECHO_SYNC_EN
//   defined   : echo_in passes through a 2-flop synchronizer; timestamps are
//               corrected by 2, so tof_out matches the unsynchronized build
//               for the same pin stimulus, and valid_out comes 2 cycles later.
//   undefined : echo_in feeds edge detection directly.
//
// Ports
//   clk_in      : system clock
//   rst_in      : synchronous active-high reset
//   start_in    : transmit burst emitted (taken only in IDLE)
//   echo_in     : receiver comparator output
//   tof_out     : time of flight in clocks, held until the next valid_out
//   valid_out   : one-cycle pulse when tof_out is updated
//   timeout_out : one-cycle pulse when no echo qualified
//   busy_out    : high in any state other than IDLE
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for start_in, timer held at 0
// BLANK   | ringdown window, all echo edges ignored
// LISTEN  | waiting for the first edge of a candidate echo train
// QUALIFY | counting in-period edges of the current candidate
// ============================================================================
module echo_tof_detector #(
   parameter int PULSE_PERIOD_CYCLES = 2500,
   parameter int PERIOD_TOL_CYCLES   = 125,
   parameter int MIN_EDGES           = 4,
   parameter int BLANKING_CYCLES     = 50000,
   parameter int MAX_TOF_CYCLES      = 2000000,
   localparam int TW                 = $clog2(MAX_TOF_CYCLES + 1)
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          start_in,
   input  logic          echo_in,
   output logic [TW-1:0] tof_out,
   output logic          valid_out,
   output logic          timeout_out,
   output logic          busy_out
);

   localparam int CW = (MIN_EDGES < 2) ? 1 : $clog2(MIN_EDGES + 1);

`ifdef ECHO_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   localparam logic [TW-1:0] LAT_V     = TW'(SYNC_LAT);
   localparam logic [TW-1:0] GAP_MIN   = TW'(PULSE_PERIOD_CYCLES - PERIOD_TOL_CYCLES);
   localparam logic [TW-1:0] GAP_MAX   = TW'(PULSE_PERIOD_CYCLES + PERIOD_TOL_CYCLES);
   localparam logic [TW-1:0] BLANK_END = TW'(BLANKING_CYCLES - 1);
   localparam logic [TW-1:0] TIMER_END = TW'(MAX_TOF_CYCLES - 1);
   localparam logic [CW-1:0] MIN_CNT   = CW'(MIN_EDGES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BLANK,
      ST_LISTEN,
      ST_QUALIFY
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [TW-1:0]   cand_q, cand_d;
   logic [TW-1:0]   last_q, last_d;
   logic [CW-1:0]   count_q, count_d;
   logic [TW-1:0]   tof_d;
   logic            valid_d;
   logic            timeout_d;
   logic            echo_s;
   logic            echo_prev_q;
   logic            echo_edge;
   logic [TW-1:0]   ts_now;
   logic [TW-1:0]   gap;
   logic            in_tol;
   logic            qualify;

`ifdef ECHO_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], echo_in};
      end
   end

   assign echo_s = sync_q[1];
`else
   assign echo_s = echo_in;
`endif

   // Timestamps are pin-referred: remove the synchronizer latency so the
   // reported time of flight does not depend on the build.
   assign echo_edge = echo_s & ~echo_prev_q;
   assign ts_now    = timer_q - LAT_V;
   // Used both as the edge-to-edge gap and, with no edge, as the silence
   // since the last accepted edge.
   assign gap       = ts_now - last_q;
   assign in_tol    = (gap >= GAP_MIN) && (gap <= GAP_MAX);
   assign busy_out  = (state_q != ST_IDLE);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 1'b1;
      cand_d    = cand_q;
      last_d    = last_q;
      count_d   = count_q;
      tof_d     = tof_out;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
      qualify   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            count_d = '0;
            if (start_in) begin
               state_d = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (timer_q == BLANK_END) begin
               state_d = ST_LISTEN;
            end
         end
         ST_LISTEN: begin
            if (echo_edge) begin
               cand_d  = ts_now;
               last_d  = ts_now;
               count_d = CW'(1);
               if (MIN_EDGES == 1) begin
                  qualify = 1'b1;
               end else begin
                  state_d = ST_QUALIFY;
               end
            end
         end
         ST_QUALIFY: begin
            if (echo_edge) begin
               if (in_tol) begin
                  count_d = count_q + 1'b1;
                  last_d  = ts_now;
                  if ((count_q + 1'b1) == MIN_CNT) begin
                     qualify = 1'b1;
                  end
               end else begin
                  cand_d  = ts_now;
                  last_d  = ts_now;
                  count_d = CW'(1);
               end
            end else if (gap > GAP_MAX) begin
               state_d = ST_LISTEN;
               count_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Qualification wins over a coincident timeout.
      if (qualify) begin
         tof_d   = cand_d;
         valid_d = 1'b1;
         state_d = ST_IDLE;
         timer_d = '0;
         count_d = '0;
      end else if (state_q != ST_IDLE && timer_q == TIMER_END) begin
         timeout_d = 1'b1;
         state_d   = ST_IDLE;
         timer_d   = '0;
         count_d   = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         timer_q     <= '0;
         cand_q      <= '0;
         last_q      <= '0;
         count_q     <= '0;
         tof_out     <= '0;
         valid_out   <= 1'b0;
         timeout_out <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         cand_q      <= cand_d;
         last_q      <= last_d;
         count_q     <= count_d;
         tof_out     <= tof_d;
         valid_out   <= valid_d;
         timeout_out <= timeout_d;
         echo_prev_q <= echo_s;
      end
   end

endmodule
